// File: rtl/machine_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : machine_job_scheduler_if
// Purpose  : Requester, engine and response bundle for machine_job_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface machine_job_scheduler_if #(
    parameter int NUM_REQ           = 4,
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_LIGHTS_W  = 4,
    parameter int MAX_NUM_BUTTONS_W = 4,
    parameter int MAX_NUM_PRESSES_W = 4,
    parameter int ID_W              = 2
);
    logic [NUM_REQ-1:0]                                          req_valid;
    logic [NUM_REQ-1:0]                                          req_ready;
    logic [NUM_REQ-1:0][MAX_NUM_LIGHTS_W-1:0]                    req_num_lights;
    logic [NUM_REQ-1:0][MAX_NUM_BUTTONS_W-1:0]                   req_num_buttons;
    logic [NUM_REQ-1:0][MAX_NUM_LIGHTS-1:0]                      req_target;
    logic [NUM_REQ-1:0][MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] req_buttons;

    logic                                         eng_start;
    logic                                         eng_ready;
    logic                                         eng_accepted;
    logic [MAX_NUM_LIGHTS_W-1:0]                  eng_num_lights;
    logic [MAX_NUM_BUTTONS_W-1:0]                 eng_num_buttons;
    logic [MAX_NUM_LIGHTS-1:0]                    eng_target;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] eng_buttons;
    logic [MAX_NUM_PRESSES_W-1:0]                 eng_min_presses;
    logic [MAX_NUM_BUTTONS-1:0]                   eng_buttons_to_press;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [MAX_NUM_PRESSES_W-1:0] rsp_min_presses;
    logic [MAX_NUM_BUTTONS-1:0]   rsp_buttons_to_press;
    logic                         rsp_no_solution;

    modport master (
        input  req_valid, req_num_lights, req_num_buttons, req_target, req_buttons,
        output req_ready,
        output eng_start, eng_accepted, eng_num_lights, eng_num_buttons, eng_target, eng_buttons,
        input  eng_ready, eng_min_presses, eng_buttons_to_press,
        output rsp_valid, rsp_id, rsp_min_presses, rsp_buttons_to_press, rsp_no_solution,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_num_lights, req_num_buttons, req_target, req_buttons,
        input  req_ready,
        input  eng_start, eng_accepted, eng_num_lights, eng_num_buttons, eng_target, eng_buttons,
        output eng_ready, eng_min_presses, eng_buttons_to_press,
        input  rsp_valid, rsp_id, rsp_min_presses, rsp_buttons_to_press, rsp_no_solution,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/machine_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : machine_job_scheduler
// Purpose  : Round-robin sharing of one configure_machine engine among
//            NUM_REQ requesters, with tagged responses and press totals.
// Revision : 1.0 - initial release
// ============================================================================
module machine_job_scheduler #(
    parameter int NUM_REQ           = 4,
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_LIGHTS_W  = ($clog2(MAX_NUM_LIGHTS + 1) < 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = ($clog2(MAX_NUM_BUTTONS + 1) < 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W,
    parameter int TOTAL_W           = 16,
    parameter int ID_W              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    machine_job_scheduler_if.master bus,
    input  wire logic               clear_totals,
    output logic [TOTAL_W-1:0]      total_presses,
    output logic [TOTAL_W-1:0]      jobs_done,
    output logic                    total_overflow
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]              id_q, id_d;
    logic [MAX_NUM_LIGHTS_W-1:0]  lights_q, lights_d;
    logic [MAX_NUM_BUTTONS_W-1:0] buttons_q, buttons_d;
    logic [MAX_NUM_LIGHTS-1:0]    target_q, target_d;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] wiring_q, wiring_d;
    logic [MAX_NUM_PRESSES_W-1:0] presses_q, presses_d;
    logic [MAX_NUM_BUTTONS-1:0]   press_set_q, press_set_d;
    logic                         no_sol_q, no_sol_d;
    logic [TOTAL_W-1:0]           total_q, total_d;
    logic [TOTAL_W-1:0]           jobs_q, jobs_d;
    logic                         ovf_q, ovf_d;

    logic                         grant_found;
    logic [ID_W-1:0]              grant_idx;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         rsp_handshake;
    logic [TOTAL_W:0]             sum;
    int                           pos;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!grant_found && bus.req_valid[pos]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(pos);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && (state_q == ST_IDLE) && grant_found && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        lights_d    = lights_q;
        buttons_d   = buttons_q;
        target_d    = target_q;
        wiring_d    = wiring_q;
        presses_d   = presses_q;
        press_set_d = press_set_q;
        no_sol_d    = no_sol_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d   = ST_START;
                    id_d      = grant_idx;
                    lights_d  = bus.req_num_lights[grant_idx];
                    buttons_d = bus.req_num_buttons[grant_idx];
                    target_d  = bus.req_target[grant_idx];
                    wiring_d  = bus.req_buttons[grant_idx];
                    if (int'(grant_idx) + 1 >= NUM_REQ) rr_ptr_d = '0;
                    else                                rr_ptr_d = grant_idx + ID_W'(1);
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.eng_ready) begin
                    state_d     = ST_RESPOND;
                    presses_d   = bus.eng_min_presses;
                    press_set_d = bus.eng_buttons_to_press;
                    no_sol_d    = &bus.eng_min_presses;
                end
            end
            ST_RESPOND: if (bus.rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign rsp_handshake = (state_q == ST_RESPOND) && bus.rsp_ready;

    // A coincident clear wipes the old totals before this job is added.
    always_comb begin
        total_d = clear_totals ? '0 : total_q;
        jobs_d  = clear_totals ? '0 : jobs_q;
        ovf_d   = clear_totals ? 1'b0 : ovf_q;
        sum     = '0;
        if (rsp_handshake) begin
            if (jobs_d != '1) jobs_d = jobs_d + TOTAL_W'(1);
            if (!no_sol_q) begin
                sum = {1'b0, total_d} + (TOTAL_W + 1)'(presses_q);
                if (sum[TOTAL_W]) begin
                    total_d = '1;
                    ovf_d   = 1'b1;
                end else begin
                    total_d = sum[TOTAL_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            lights_q    <= '0;
            buttons_q   <= '0;
            target_q    <= '0;
            wiring_q    <= '0;
            presses_q   <= '0;
            press_set_q <= '0;
            no_sol_q    <= 1'b0;
            total_q     <= '0;
            jobs_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            lights_q    <= lights_d;
            buttons_q   <= buttons_d;
            target_q    <= target_d;
            wiring_q    <= wiring_d;
            presses_q   <= presses_d;
            press_set_q <= press_set_d;
            no_sol_q    <= no_sol_d;
            total_q     <= total_d;
            jobs_q      <= jobs_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.req_ready            = req_ready;
    assign bus.eng_start            = (state_q == ST_START);
    assign bus.eng_accepted         = (state_q == ST_WAIT) && bus.eng_ready;
    assign bus.eng_num_lights       = lights_q;
    assign bus.eng_num_buttons      = buttons_q;
    assign bus.eng_target           = target_q;
    assign bus.eng_buttons          = wiring_q;
    assign bus.rsp_valid            = (state_q == ST_RESPOND);
    assign bus.rsp_id               = id_q;
    assign bus.rsp_min_presses      = presses_q;
    assign bus.rsp_buttons_to_press = press_set_q;
    assign bus.rsp_no_solution      = no_sol_q;
    assign total_presses            = total_q;
    assign jobs_done                = jobs_q;
    assign total_overflow           = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_machine_job_scheduler.sv
`default_nettype none
// Testbench for machine_job_scheduler: directed table, randomized jobs against
// a transaction-level model, mid-job reset and a narrow-accumulator instance.
module tb_machine_job_scheduler;
    localparam int NR = 4, NL = 10, NB = 13, LW = 4, BW = 4, PW = 4, IDW = 2, TW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_totals = 1'b0;
    logic s_clear = 1'b0;
    logic [TW-1:0] total_presses, jobs_done;
    logic total_overflow;
    logic [3:0] s_total, s_jobs;
    logic s_ovf;

    int checks = 0;
    int errors = 0;

    int m_rr = 0, m_total = 0, m_jobs = 0;
    bit m_ovf = 1'b0;

    logic [LW-1:0]    d_l [NR];
    logic [BW-1:0]    d_b [NR];
    logic [NL-1:0]    d_t [NR];
    logic [NB*NL-1:0] d_w [NR];

    always #5 clk = ~clk;

    machine_job_scheduler_if #(.NUM_REQ(NR), .MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB),
        .MAX_NUM_LIGHTS_W(LW), .MAX_NUM_BUTTONS_W(BW), .MAX_NUM_PRESSES_W(PW), .ID_W(IDW)) bus ();
    machine_job_scheduler_if #(.NUM_REQ(1), .MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB),
        .MAX_NUM_LIGHTS_W(LW), .MAX_NUM_BUTTONS_W(BW), .MAX_NUM_PRESSES_W(PW), .ID_W(1)) sbus ();

    machine_job_scheduler #(.NUM_REQ(NR), .MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB), .TOTAL_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clear_totals(clear_totals),
        .total_presses(total_presses), .jobs_done(jobs_done), .total_overflow(total_overflow));

    machine_job_scheduler #(.NUM_REQ(1), .MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB), .TOTAL_W(4)) sdut (
        .clk(clk), .rst_n(rst_n), .bus(sbus), .clear_totals(s_clear),
        .total_presses(s_total), .jobs_done(s_jobs), .total_overflow(s_ovf));

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_desc(input int i);
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        d_l[i] = LW'($urandom_range(1, NL));
        d_b[i] = BW'($urandom_range(1, NB));
        d_t[i] = NL'($urandom);
        d_w[i] = w[NB*NL-1:0];
        bus.req_num_lights[i]  = d_l[i];
        bus.req_num_buttons[i] = d_b[i];
        bus.req_target[i]      = d_t[i];
        bus.req_buttons[i]     = d_w[i];
    endtask

    function automatic int pick_id(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++) begin
            if (mask[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_job(input int g, input int res, input bit clr);
        m_rr = (g + 1) % NR;
        if (clr) begin m_total = 0; m_jobs = 0; m_ovf = 1'b0; end
        if (m_jobs < 65535) m_jobs++;
        if (res != 15) begin
            m_total += res;
            if (m_total > 65535) begin m_total = 65535; m_ovf = 1'b1; end
        end
    endtask

    task automatic check_held(input int id);
        check("eng_num_lights", bus.eng_num_lights, d_l[id]);
        check("eng_num_buttons", bus.eng_num_buttons, d_b[id]);
        check("eng_target", bus.eng_target, d_t[id]);
        check("eng_buttons", bus.eng_buttons, d_w[id]);
    endtask

    task automatic check_rsp(input int id, input logic [PW-1:0] res, input logic [NB-1:0] btp);
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_id", bus.rsp_id, id);
        check("rsp_min_presses", bus.rsp_min_presses, res);
        check("rsp_buttons_to_press", bus.rsp_buttons_to_press, btp);
        check("rsp_no_solution", bus.rsp_no_solution, (res == 4'hF));
        check("req_ready_in_respond", bus.req_ready, 0);
        check("eng_start_in_respond", bus.eng_start, 0);
        check("eng_accepted_in_respond", bus.eng_accepted, 0);
    endtask

    // Enters at a negedge with the DUT idle; returns one negedge after the response handshake.
    task automatic run_job(input logic [NR-1:0] mask, input logic [PW-1:0] res, input int lat,
                           input int stall, input bit clr, input bit lag, input int exp_id);
        int n;
        logic [NB-1:0] btp;
        n = 0;
        btp = NB'($urandom);
        bus.req_valid = mask;
        #1;
        while (bus.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
        check("req_ready_grant", bus.req_ready, 1 << exp_id);
        check("eng_start_at_grant", bus.eng_start, 0);
        @(negedge clk); #1;
        check("eng_start_pulse", bus.eng_start, 1);
        check_held(exp_id);
        @(negedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            check("eng_start_in_wait", bus.eng_start, 0);
            check("eng_accepted_early", bus.eng_accepted, 0);
            @(negedge clk); #1;
        end
        bus.eng_ready = 1'b1;
        bus.eng_min_presses = res;
        bus.eng_buttons_to_press = btp;
        #1;
        check("eng_accepted", bus.eng_accepted, 1);
        @(negedge clk);
        bus.eng_ready = lag;
        bus.eng_min_presses = ~res;
        bus.eng_buttons_to_press = ~btp;
        #1;
        for (int i = 0; i < stall; i++) begin
            check_rsp(exp_id, res, btp);
            check_held(exp_id);
            @(negedge clk);
            bus.eng_ready = 1'b0;
            #1;
        end
        bus.rsp_ready = 1'b1;
        clear_totals = clr;
        #1;
        check_rsp(exp_id, res, btp);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        clear_totals = 1'b0;
        bus.eng_ready = 1'b0;
        #1;
        check("rsp_valid_after", bus.rsp_valid, 0);
        model_job(exp_id, res, clr);
    endtask

    task automatic small_job(input logic [PW-1:0] res, input bit clr, input int exp_total, input bit exp_ovf);
        int n;
        n = 0;
        sbus.req_valid = 1'b1;
        #1;
        while (sbus.req_ready == 1'b0 && n < 20) begin @(negedge clk); #1; n++; end
        check("s_req_ready", sbus.req_ready, 1);
        @(negedge clk); sbus.req_valid = 1'b0;
        @(negedge clk); sbus.eng_ready = 1'b1; sbus.eng_min_presses = res;
        @(negedge clk); sbus.eng_ready = 1'b0; sbus.rsp_ready = 1'b1; s_clear = clr; #1;
        check("s_rsp_valid", sbus.rsp_valid, 1);
        @(negedge clk); sbus.rsp_ready = 1'b0; s_clear = 1'b0; #1;
        check("s_total_presses", s_total, exp_total);
        check("s_total_overflow", s_ovf, exp_ovf);
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic [PW-1:0] res;
        int lat;
        int stall;
        bit clr;
        bit lag;
        int exp_id;
        int exp_total;
        int exp_jobs;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'b1111, 4'd1,  0, 0, 1'b0, 1'b0, 0, 1,  1};
        tbl[1] = '{4'b1111, 4'd2,  1, 1, 1'b0, 1'b1, 1, 3,  2};
        tbl[2] = '{4'b1111, 4'd0,  2, 0, 1'b0, 1'b0, 2, 3,  3};
        tbl[3] = '{4'b1111, 4'd5,  0, 2, 1'b0, 1'b1, 3, 8,  4};
        tbl[4] = '{4'b1111, 4'd4,  3, 0, 1'b0, 1'b0, 0, 12, 5};
        tbl[5] = '{4'b0100, 4'd3,  1, 0, 1'b1, 1'b0, 2, 3,  1};
        tbl[6] = '{4'b0010, 4'd15, 0, 5, 1'b0, 1'b1, 1, 3,  2};
        tbl[7] = '{4'b1001, 4'd2,  0, 0, 1'b0, 1'b0, 3, 5,  3};
        tbl[8] = '{4'b1001, 4'd13, 2, 1, 1'b0, 1'b0, 0, 18, 4};
        tbl[9] = '{4'b1000, 4'd0,  0, 0, 1'b0, 1'b1, 3, 18, 5};

        bus.req_valid = '0;
        bus.eng_ready = 1'b0;
        bus.eng_min_presses = '0;
        bus.eng_buttons_to_press = '0;
        bus.rsp_ready = 1'b0;
        sbus.req_valid = '0;
        sbus.req_num_lights = '0;
        sbus.req_num_buttons = '0;
        sbus.req_target = '0;
        sbus.req_buttons = '0;
        sbus.eng_ready = 1'b0;
        sbus.eng_min_presses = '0;
        sbus.eng_buttons_to_press = '0;
        sbus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) new_desc(i);

        // Reset state, with all requesters asking.
        bus.req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_eng_start", bus.eng_start, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_eng_lights", bus.eng_num_lights, 0);
        check("reset_total", total_presses, 0);
        check("reset_jobs", jobs_done, 0);
        check("reset_overflow", total_overflow, 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("idle_req_ready", bus.req_ready, 0);
            check("idle_eng_start", bus.eng_start, 0);
        end

        for (int r = 0; r < 10; r++) begin
            run_job(tbl[r].mask, tbl[r].res, tbl[r].lat, tbl[r].stall, tbl[r].clr, tbl[r].lag, tbl[r].exp_id);
            check("tbl_total_presses", total_presses, tbl[r].exp_total);
            check("tbl_jobs_done", jobs_done, tbl[r].exp_jobs);
            check("tbl_total_overflow", total_overflow, 0);
        end

        for (int j = 0; j < 40; j++) begin
            logic [NR-1:0] mask;
            logic [PW-1:0] res;
            mask = NR'($urandom_range(1, 15));
            res = ($urandom_range(0, 7) == 0) ? 4'hF : PW'($urandom_range(0, NB));
            for (int i = 0; i < NR; i++) new_desc(i);
            run_job(mask, res, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, pick_id(mask));
            check("rnd_total_presses", total_presses, m_total);
            check("rnd_jobs_done", jobs_done, m_jobs);
            check("rnd_total_overflow", total_overflow, m_ovf);
        end

        // Reset while the engine is working on a job.
        new_desc(2);
        bus.req_valid = 4'b0100;
        #1;
        check("pre_reset_grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        bus.eng_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_eng_accepted", bus.eng_accepted, 0);
        check("midreset_eng_start", bus.eng_start, 0);
        check("midreset_rsp_valid", bus.rsp_valid, 0);
        check("midreset_req_ready", bus.req_ready, 0);
        check("midreset_eng_lights", bus.eng_num_lights, 0);
        check("midreset_total", total_presses, 0);
        check("midreset_jobs", jobs_done, 0);
        @(negedge clk);
        @(negedge clk);
        bus.eng_ready = 1'b0;
        rst_n = 1'b1;
        m_rr = 0; m_total = 0; m_jobs = 0; m_ovf = 1'b0;
        for (int i = 0; i < NR; i++) new_desc(i);
        run_job(4'b1111, 4'd5, 1, 1, 1'b0, 1'b0, 0);
        check("postreset_total", total_presses, 5);
        check("postreset_jobs", jobs_done, 1);

        // Narrow accumulator: saturation and clear-then-add.
        small_job(4'd9, 1'b0, 9, 1'b0);
        small_job(4'd9, 1'b0, 15, 1'b1);
        small_job(4'd2, 1'b1, 2, 1'b0);
        check("s_jobs_done", s_jobs, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
